// File: rtl/fir_sum_pipe_pkg.sv
// fir_sum_pipe shared helpers: tree depth, sum width, per-level shape.
// Optional rounded-mean output is enabled by FIR_SUM_AVG_EN.
package fir_sum_pkg;

  function automatic int lvl_of(input int taps);
    return $clog2(taps);
  endfunction

  function automatic int sw_of(input int w, input int taps);
    return w + $clog2(taps);
  endfunction

  function automatic int lvl_width(input int w, input int level);
    return w + level;
  endfunction

  function automatic int lvl_count(input int taps, input int level);
    return (taps + (1 << level) - 1) >> level;
  endfunction

endpackage

// File: rtl/fir_sum_pipe_if.sv
// fir_sum_pipe sample/result bundle.
// The avg signal exists only when FIR_SUM_AVG_EN is defined.
interface fir_sum_pipe_if
  import fir_sum_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
);
  localparam int SW = sw_of(W, TAPS);

  logic          clear;
  logic          in_valid;
  logic [W-1:0]  a;
  logic          out_valid;
  logic [SW-1:0] s;
`ifdef FIR_SUM_AVG_EN
  logic [W-1:0]  avg;
`endif

  modport master (
    output clear,
    output in_valid,
    output a,
`ifdef FIR_SUM_AVG_EN
    input  avg,
`endif
    input  out_valid,
    input  s
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  a,
`ifdef FIR_SUM_AVG_EN
    output avg,
`endif
    output out_valid,
    output s
  );

endinterface

// File: rtl/fir_sum_pipe_add_level.sv
// One registered adder-tree level: pairwise sums, odd operand
// paired with zero, output one bit wider than the inputs.
module fir_sum_add_level #(
  parameter int N  = 2,
  parameter int IW = 16,
  localparam int M  = (N + 1) / 2,
  localparam int OW = IW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [N*IW-1:0] din,
  output logic [M*OW-1:0] dout
);

  logic [M*OW-1:0] sum;

  for (genvar j = 0; j < M; j++) begin : g_pair
    logic [OW-1:0] lo;
    logic [OW-1:0] hi;
    assign lo = {1'b0, din[2*j*IW +: IW]};
    if (2*j + 1 < N) begin : g_two
      assign hi = {1'b0, din[(2*j+1)*IW +: IW]};
    end else begin : g_one
      assign hi = '0;
    end
    assign sum[j*OW +: OW] = lo + hi;
  end

  // level register, flushed by reset or clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else begin
      dout <= sum;
    end
  end

endmodule

// File: rtl/fir_sum_pipe.sv
// Moving-sum FIR: TAPS-deep delay line feeding a registered adder tree.
// Define FIR_SUM_AVG_EN to add the rounded-mean avg output.
module fir_sum_pipe
  import fir_sum_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input logic           clk,
  input logic           reset,
  fir_sum_pipe_if.slave bus
);

  localparam int LVL = lvl_of(TAPS);
  localparam int SW  = sw_of(W, TAPS);
  localparam int FW  = $clog2(TAPS + 1);

  logic [W-1:0]      tap [TAPS];
  logic [TAPS*W-1:0] tap_flat;
  logic [FW-1:0]     fill;
  logic              acc;
  logic              win;
  logic              win_q;
  logic [LVL-1:0]    vld;

  assign acc = bus.in_valid & ~bus.clear;
  assign win = acc & (fill >= FW'(TAPS - 1));

  for (genvar i = 0; i < TAPS; i++) begin : g_flat
    assign tap_flat[i*W +: W] = tap[i];
  end

  // delay line shifts on each accepted sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
    end else if (bus.in_valid) begin
      tap[0] <= bus.a;
      for (int i = 1; i < TAPS; i++) tap[i] <= tap[i-1];
    end
  end

  // fill count saturates once the window is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else if (bus.clear) begin
      fill <= '0;
    end else if (bus.in_valid && fill != FW'(TAPS)) begin
      fill <= fill + 1'b1;
    end
  end

  // valid flag aligned with the taps, then one bit per tree level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= 1'b0;
      vld   <= '0;
    end else if (bus.clear) begin
      win_q <= 1'b0;
      vld   <= '0;
    end else begin
      win_q  <= win;
      vld[0] <= win_q;
      for (int i = 1; i < LVL; i++) vld[i] <= vld[i-1];
    end
  end

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int NI = lvl_count(TAPS, l);
    localparam int NO = lvl_count(TAPS, l + 1);
    localparam int IW = lvl_width(W, l);
    logic [NI*IW-1:0]     d;
    logic [NO*(IW+1)-1:0] q;
    if (l == 0) begin : g_src
      assign d = tap_flat;
    end else begin : g_chain
      assign d = g_lvl[l-1].q;
    end
    fir_sum_add_level #(
      .N  (NI),
      .IW (IW)
    ) u_add (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .din   (d),
      .dout  (q)
    );
  end

  assign bus.s         = g_lvl[LVL-1].q;
  assign bus.out_valid = vld[LVL-1];

`ifdef FIR_SUM_AVG_EN
  logic [SW:0] rnd;
  logic [SW:0] shf;

  assign rnd     = {1'b0, bus.s} + (SW+1)'(1 << (LVL - 1));
  assign shf     = rnd >> LVL;
  assign bus.avg = (|shf[SW:W]) ? '1 : shf[W-1:0];
`endif

endmodule

// File: tb/tb_fir_sum_pipe.sv
// Directed bench for fir_sum_pipe: TAPS=4/W=16 and TAPS=5/W=8 instances.
// avg checks are active when FIR_SUM_AVG_EN is defined.
module tb_fir_sum_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_sum_pipe_if #(.W(16), .TAPS(4)) b4 ();
  fir_sum_pipe_if #(.W(8),  .TAPS(5)) b5 ();

  fir_sum_pipe #(.W(16), .TAPS(4)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  fir_sum_pipe #(.W(8), .TAPS(5)) u5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b5)
  );

  typedef struct {
    bit          clr;
    bit          iv;
    logic [15:0] a;
    bit          ov;
    logic [17:0] s;
    logic [15:0] avg;
  } vec_t;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  vec_t t4 [$];
  vec_t t5 [$];

  function automatic vec_t mk(bit clr, bit iv, int a, bit ov, int s, int avg);
    vec_t v;
    v.clr = clr;
    v.iv  = iv;
    v.a   = 16'(a);
    v.ov  = ov;
    v.s   = 18'(s);
    v.avg = 16'(avg);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic drive(input bit sel, input bit clr, input bit iv,
                       input logic [15:0] a);
    if (!sel) begin
      b4.clear = clr; b4.in_valid = iv; b4.a = a;
      b5.clear = 1'b0; b5.in_valid = 1'b0; b5.a = '0;
    end else begin
      b5.clear = clr; b5.in_valid = iv; b5.a = a[7:0];
      b4.clear = 1'b0; b4.in_valid = 1'b0; b4.a = '0;
    end
  endtask

  task automatic apply(input bit sel, input vec_t v, input string nm);
    drive(sel, v.clr, v.iv, v.a);
    @(posedge clk);
    #1;
    if (!sel) begin
      chk({nm, " ov"}, 32'(b4.out_valid), 32'(v.ov));
      if (v.ov) begin
        chk({nm, " s"}, 32'(b4.s), 32'(v.s));
`ifdef FIR_SUM_AVG_EN
        chk({nm, " avg"}, 32'(b4.avg), 32'(v.avg));
`endif
      end
    end else begin
      chk({nm, " ov"}, 32'(b5.out_valid), 32'(v.ov));
      if (v.ov) begin
        chk({nm, " s"}, 32'(b5.s), 32'(v.s));
`ifdef FIR_SUM_AVG_EN
        chk({nm, " avg"}, 32'(b5.avg), 32'(v.avg));
`endif
      end
    end
  endtask

  initial begin
    // basic 1..5
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,1,2, 0,0,0));
    t4.push_back(mk(0,1,3, 0,0,0));
    t4.push_back(mk(0,1,4, 0,0,0));
    t4.push_back(mk(0,1,5, 0,0,0));
    t4.push_back(mk(0,0,0, 1,10,3));
    t4.push_back(mk(0,0,0, 1,14,4));
    t4.push_back(mk(0,0,0, 0,0,0));
    // gapped input
    t4.push_back(mk(1,0,0, 0,0,0));
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,1,2, 0,0,0));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(0,1,3, 0,0,0));
    t4.push_back(mk(0,1,4, 0,0,0));
    t4.push_back(mk(0,1,5, 0,0,0));
    t4.push_back(mk(0,0,0, 1,10,3));
    t4.push_back(mk(0,0,0, 1,14,4));
    t4.push_back(mk(0,0,0, 0,0,0));
    // clear with in_valid mid-stream, results in flight
    t4.push_back(mk(0,1,6, 0,0,0));
    t4.push_back(mk(0,1,7, 0,0,0));
    t4.push_back(mk(1,1,9, 0,0,0));
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,1,1, 0,0,0));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(0,0,0, 1,4,1));
    t4.push_back(mk(0,0,0, 0,0,0));
    // all-ones stress
    t4.push_back(mk(1,0,0, 0,0,0));
    t4.push_back(mk(0,1,16'hFFFF, 0,0,0));
    t4.push_back(mk(0,1,16'hFFFF, 0,0,0));
    t4.push_back(mk(0,1,16'hFFFF, 0,0,0));
    t4.push_back(mk(0,1,16'hFFFF, 0,0,0));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(0,0,0, 1,18'h3FFFC,16'hFFFF));
    t4.push_back(mk(0,0,0, 0,0,0));
    t4.push_back(mk(1,0,0, 0,0,0));

    // TAPS=5, W=8: LVL=3
    t5.push_back(mk(0,1,1, 0,0,0));
    t5.push_back(mk(0,1,2, 0,0,0));
    t5.push_back(mk(0,1,3, 0,0,0));
    t5.push_back(mk(0,1,4, 0,0,0));
    t5.push_back(mk(0,1,5, 0,0,0));
    t5.push_back(mk(0,1,6, 0,0,0));
    t5.push_back(mk(0,0,0, 0,0,0));
    t5.push_back(mk(0,0,0, 1,15,2));
    t5.push_back(mk(0,0,0, 1,20,3));
    t5.push_back(mk(0,0,0, 0,0,0));

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst4 ov", 32'(b4.out_valid), 32'd0);
    chk("rst4 s",  32'(b4.s), 32'd0);
    chk("rst5 ov", 32'(b5.out_valid), 32'd0);
    chk("rst5 s",  32'(b5.s), 32'd0);
`ifdef FIR_SUM_AVG_EN
    chk("rst4 avg", 32'(b4.avg), 32'd0);
`endif
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < t4.size(); i++)
      apply(1'b0, t4[i], $sformatf("t4[%0d]", i));

    // async reset while results are in flight
    apply(1'b0, mk(0,1,1, 0,0,0), "ar0");
    apply(1'b0, mk(0,1,2, 0,0,0), "ar1");
    apply(1'b0, mk(0,1,3, 0,0,0), "ar2");
    apply(1'b0, mk(0,1,4, 0,0,0), "ar3");
    apply(1'b0, mk(0,1,5, 0,0,0), "ar4");
    apply(1'b0, mk(0,0,0, 1,10,3), "ar5");
    #2 reset = 1'b0;
    #1;
    chk("arst ov", 32'(b4.out_valid), 32'd0);
    chk("arst s",  32'(b4.s), 32'd0);
`ifdef FIR_SUM_AVG_EN
    chk("arst avg", 32'(b4.avg), 32'd0);
`endif
    #1 reset = 1'b1;
    apply(1'b0, mk(0,1,7, 0,0,0), "ar6");
    apply(1'b0, mk(0,1,7, 0,0,0), "ar7");
    apply(1'b0, mk(0,1,7, 0,0,0), "ar8");
    apply(1'b0, mk(0,1,7, 0,0,0), "ar9");
    apply(1'b0, mk(0,0,0, 0,0,0), "ar10");
    apply(1'b0, mk(0,0,0, 1,28,7), "ar11");
    apply(1'b0, mk(0,0,0, 0,0,0), "ar12");

    for (int i = 0; i < t5.size(); i++)
      apply(1'b1, t5[i], $sformatf("t5[%0d]", i));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fir_sum_pipe.md
# fir_sum_pipe

Parametrised moving-sum FIR filter: successor to the fixed 4-tap, 16-bit unit-coefficient filter. Accepts one unsigned sample per `in_valid` cycle into a TAPS-deep delay line and emits the full-precision sum of the most recent TAPS samples through a registered adder tree (one register level per tree level). It adds a valid handshake, warm-up gating, synchronous flush, and an optional rounded-mean output. It sits in the datapath directly after the sample source and replaces the fixed filter.

## Interface
- `W`, 16, sample width in bits (unsigned), ≥1
- `TAPS`, 4, window length, ≥2 (any integer; non-power-of-two trees are zero-padded)
- Derived: `LVL = $clog2(TAPS)`, `SW = W + LVL`

Ports:
- `clk`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `clear`  in  1  synchronous flush, active-high
- `in_valid`  in  1  `a` carries a sample this cycle
- `a`  in  W  input sample
- `out_valid`  out  1  `s` holds a full-window sum
- `s`  out  SW  window sum
- `avg`  out  W  rounded mean; present only with `FIR_SUM_AVG_EN`

## Operation
- Delay line `tap[0..TAPS-1]`, each W bits. On an edge with `in_valid=1` and `clear=0`: `tap[0]<=a`, `tap[i]<=tap[i-1]`. With `in_valid=0`, the taps hold.
- Fill counter `fill` runs 0..TAPS and saturates at TAPS. It increments on each accepted sample.
- A sample is "window-complete" when it is accepted with `fill ≥ TAPS-1`.
- Adder tree level 1 registers pairwise sums of the taps. Each later level registers pairwise sums of the level before. Level LVL is the `s` register itself. Odd operands pass through with a zero partner. Each level is 1 bit wider than its inputs, so there is no overflow at `SW` bits.
- A valid shift register of LVL bits runs alongside the tree and advances every cycle (no backpressure). Stage 0 input is `in_valid & window-complete & ~clear`. Its last bit is `out_valid`.
- The tree advances every cycle. When `out_valid=0`, `s` carries don't-care-but-deterministic values and the bench checks `s` only when `out_valid=1`.
- `clear=1` zeroes all taps, `fill`, every tree register, and the valid pipeline on that edge. In-flight results are discarded.
- `clear` and `in_valid` asserted in the same cycle: `clear` wins and the sample is dropped.
- Asserting `reset` mid-operation has the same effect as `clear`, but takes effect asynchronously. After deassertion the block starts in the empty state.

## Timing
- Reset values: `s=0`, `out_valid=0`, `avg=0`, all taps, tree registers and `fill` = 0.
- Latency: a window-complete sample accepted at edge k gives `out_valid=1` with the corresponding sum on `s` after edge k+LVL (TAPS=4: k+2).
- Throughput: one result per accepted sample. Gaps in `in_valid` appear as identical gaps in `out_valid`.
- The first `out_valid` after reset or `clear` corresponds to the TAPS-th accepted sample.
- `clear` at edge k suppresses every `out_valid` that would have appeared at edges k+1..k+LVL.

## Configuration
- Macro: `FIR_SUM_AVG_EN`.
- Defined: adds the `avg` port. `avg = (s + 2^(LVL-1)) >> LVL`, computed in SW+1 bits (round half up) and combinational from `s`. It is valid whenever `out_valid=1`.
  - When TAPS is a power of two, `avg` is the rounded mean and cannot exceed 2^W-1.
  - Otherwise `avg` is the sum scaled by 2^-LVL and is saturated to 2^W-1.
- Undefined: no `avg` port and no rounding logic. The rest of the behaviour is identical.

## Structure
- Package `fir_sum_pkg` holds:
  - the `LVL`/`SW` derivation helpers
  - a function returning level width (`W + level`)
  - the per-level operand-count function (`ceil(TAPS / 2^level)`)
- Sub-module `fir_sum_add_level`: one registered adder-tree level, parametrised by input count and input width. It has async active-low reset and sync clear, and is generated LVL times in the top.

## Test plan
- Reset then W=16, TAPS=4; feed 1,2,3,4,5 on consecutive cycles. Required: `out_valid` is first high 2 edges after the sample 4 edge, `s`=10, then `s`=14. With `FIR_SUM_AVG_EN`: `avg`=3, then 4.
- All-ones stress: W=16, TAPS=4, four samples of 0xFFFF. Required: `s`=0x3FFFC and `avg`=0xFFFF (no wrap).
- Gapped input: samples 1,2,(gap 3 cycles),3,4,5. Required: exactly two `out_valid` pulses, `s`=10 and 14, each 2 edges after its sample.
- `clear` together with `in_valid`=1 carrying value 9, mid-stream after `fill`=4. Required: the sample is dropped, no `out_valid` for the next 2 edges, and the next valid `s` needs 4 new samples.
- Asynchronous `reset` pulse between edges while results are in flight. Required: `s`=0 and `out_valid`=0 immediately. After release, 4 samples of 7 give `s`=28.
- TAPS=5, W=8: samples 1..6. Required: `LVL`=3, first `s`=15 and then `s`=20, each 3 edges after its sample.
